// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings,
// default latencies, datapath widths and the two-state control encoding.
package mdu_pkg;

    localparam int MDU_W     = 32;
    localparam int MDU_RES_W = 64;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

    // MDUOp field encodings; 6 and 7 are reserved no-ops.
    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5,
        MDU_NOP6  = 3'd6,
        MDU_NOP7  = 3'd7
    } mdu_op_e;

    // Control view of the unit; derived from the cycle counter.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/md_unit.sv
// MIPS multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU compute at the start edge into a shadow register and commit to
// HI/LO after MULT_CYCLES; DIV/DIVU likewise after DIV_CYCLES. MTHI/MTLO
// write in one cycle. Divide support is present only when MDU_DIV_EN is
// defined; otherwise DIV/DIVU behave as no-ops.
// Handshake: start is a one-cycle request taken only while busy is low;
// any start seen while busy is high is dropped without side effects.
module md_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       MDUOp,
    input  logic [MDU_W-1:0] A,
    input  logic [MDU_W-1:0] B,
    output logic [MDU_W-1:0] hi,
    output logic [MDU_W-1:0] lo,
    output logic             busy
);

    localparam int CNT_W = $clog2(max_int(MULT_CYCLES, DIV_CYCLES) + 1);

    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [MDU_RES_W-1:0] shadow, shadow_n;
    logic                 dz, dz_n;
    logic [MDU_W-1:0]     hi_n, lo_n;
    mdu_state_e           state;

    logic [MDU_RES_W-1:0] mul_s, mul_u;

    // Both products are formed at full 64-bit width; the signed one uses
    // sign-extended operands so the low 64 bits are the exact signed product.
    assign mul_u = {{MDU_W{1'b0}}, A} * {{MDU_W{1'b0}}, B};
    assign mul_s = {{MDU_W{A[MDU_W-1]}}, A} * {{MDU_W{B[MDU_W-1]}}, B};

`ifdef MDU_DIV_EN
    logic             div_signed;
    logic [MDU_W-1:0] dvd_mag, dvs_mag, q_mag, r_mag, div_q, div_r;
    logic             q_neg, r_neg;

    // One unsigned divider serves both DIV and DIVU: signed operands are
    // reduced to magnitudes and the signs are reapplied afterwards, which
    // also gives a defined result for 0x80000000 / -1.
    always_comb begin
        div_signed = (MDUOp == MDU_DIV);
        dvd_mag    = (div_signed && A[MDU_W-1]) ? (~A + 1'b1) : A;
        dvs_mag    = (div_signed && B[MDU_W-1]) ? (~B + 1'b1) : B;
        q_mag      = '0;
        r_mag      = '0;
        if (dvs_mag != '0) begin
            q_mag = dvd_mag / dvs_mag;
            r_mag = dvd_mag % dvs_mag;
        end
        q_neg = div_signed && (A[MDU_W-1] ^ B[MDU_W-1]);
        r_neg = div_signed && A[MDU_W-1];
        div_q = q_neg ? (~q_mag + 1'b1) : q_mag;
        div_r = r_neg ? (~r_mag + 1'b1) : r_mag;
    end
`endif

    // The counter is the only control state: nonzero means an operation is in flight.
    always_comb begin
        state = (cnt != '0) ? ST_RUN : ST_IDLE;
        busy  = (state == ST_RUN);
    end

    // Next-state logic: accept requests in IDLE, count down and commit in RUN.
    always_comb begin
        cnt_n    = cnt;
        shadow_n = shadow;
        dz_n     = dz;
        hi_n     = hi;
        lo_n     = lo;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    case (mdu_op_e'(MDUOp))
                        MDU_MULT: begin
                            shadow_n = mul_s;
                            dz_n     = 1'b0;
                            cnt_n    = CNT_W'(MULT_CYCLES);
                        end
                        MDU_MULTU: begin
                            shadow_n = mul_u;
                            dz_n     = 1'b0;
                            cnt_n    = CNT_W'(MULT_CYCLES);
                        end
`ifdef MDU_DIV_EN
                        MDU_DIV, MDU_DIVU: begin
                            shadow_n = {div_r, div_q};
                            dz_n     = (B == '0);
                            cnt_n    = CNT_W'(DIV_CYCLES);
                        end
`endif
                        MDU_MTHI: hi_n = A;
                        MDU_MTLO: lo_n = A;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                cnt_n = cnt - CNT_W'(1);
                // Final edge of the operation: commit unless it was a divide by zero.
                if (cnt == CNT_W'(1) && !dz) begin
                    hi_n = shadow[MDU_RES_W-1:MDU_W];
                    lo_n = shadow[MDU_W-1:0];
                end
            end
            default: ;
        endcase
    end

    // State registers; reset clears everything, dropping any pending result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            shadow <= '0;
            dz     <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            cnt    <= cnt_n;
            shadow <= shadow_n;
            dz     <= dz_n;
            hi     <= hi_n;
            lo     <= lo_n;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases plus randomized operations
// compared against an arithmetic reference model of HI/LO and busy length.
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  MDUOp;
  logic [31:0] A, B;
  logic [31:0] hi, lo;
  logic        busy;

  int n_tests = 0;
  int n_fail = 0;

  logic [31:0] m_hi, m_lo;
  logic [63:0] exp_q[$];

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .MDUOp(MDUOp),
    .A(A), .B(B), .hi(hi), .lo(lo), .busy(busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model: expected busy duration of an accepted request
  function automatic int exp_busy(input logic [2:0] op);
    if (op == 3'd0 || op == 3'd1) return MC;
    if ((op == 3'd2 || op == 3'd3) && DIV_EN) return DC;
    return 0;
  endfunction

  // reference model: architectural effect on HI/LO
  task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint q, r;
    logic [63:0] p;
    case (op)
      3'd0: begin
        q = longint'($signed(a)) * longint'($signed(b));
        p = q;
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      3'd1: begin
        p = {32'd0, a} * {32'd0, b};
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      3'd2: if (DIV_EN && b != 0) begin
        q = longint'($signed(a)) / longint'($signed(b));
        r = longint'($signed(a)) % longint'($signed(b));
        m_lo = q[31:0]; m_hi = r[31:0];
      end
      3'd3: if (DIV_EN && b != 0) begin
        m_lo = a / b; m_hi = a % b;
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  // driver: issue one request at the current low phase, then measure busy
  // and compare HI/LO once busy has fallen
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int cnt;
    model_apply(op, a, b);
    exp_q.push_back({m_hi, m_lo});
    start = 1'b1; MDUOp = op; A = a; B = b;
    @(posedge clk);
    #1;
    start = 1'b0; MDUOp = 3'd7; A = $urandom; B = $urandom;
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!busy) break;
      cnt++;
    end
    check({tag, "_busy"}, 64'(cnt), 64'(exp_busy(op)));
    check({tag, "_hilo"}, {hi, lo}, exp_q.pop_front());
  endtask

  initial begin
    int cnt;
    logic [2:0]  op;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; MDUOp = 3'd7; A = '0; B = '0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    check("reset_state", {31'd0, busy, hi, lo}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // directed cases from the plan
    run_op("mult", 3'd0, 32'hFFFFFFFF, 32'h00000002);
    check("mult_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFE);
    run_op("multu", 3'd1, 32'hFFFFFFFF, 32'h00000002);
    check("multu_const", {hi, lo}, 64'h00000001_FFFFFFFE);
    run_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'd2);
    run_op("divu", 3'd3, 32'd7, 32'd2);
    run_op("mtlo0", 3'd5, 32'd0, 32'd0);
    run_op("mthi", 3'd4, 32'h12345678, 32'd0);
    check("mthi_const", {32'd0, hi}, 64'h12345678);
    run_op("divu_dz", 3'd3, 32'd7, 32'd0);
    check("divu_dz_const", {hi, lo}, 64'h12345678_00000000);
    run_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF);
    run_op("nop6", 3'd6, 32'hAAAA5555, 32'd3);

    // MTLO request while a multiply is in flight must be dropped
    model_apply(3'd0, 32'h00001234, 32'hFFFF0001);
    exp_q.push_back({m_hi, m_lo});
    start = 1'b1; MDUOp = 3'd0; A = 32'h00001234; B = 32'hFFFF0001;
    @(posedge clk);
    #1 start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (!busy) break;
      cnt++;
      if (cnt == 2) begin
        start = 1'b1; MDUOp = 3'd5; A = 32'h0000DEAD;
      end
    end
    check("ign_busy", 64'(cnt), 64'(MC));
    check("ign_hilo", {hi, lo}, exp_q.pop_front());

    // asynchronous reset in the middle of a multiply
    start = 1'b1; MDUOp = 3'd0; A = 32'd3; B = 32'd5;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #1 check("rst_mid", {31'd0, busy, hi, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (12) @(negedge clk);
    check("rst_after", {31'd0, busy, hi, lo}, 64'd0);

    // randomized sequence, issued back to back
    for (int k = 0; k < 60; k++) begin
      op = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: ra = 32'h80000000;
        2: rb = 32'($urandom_range(1, 9));
        3: rb = 32'hFFFFFFFF;
        default: ;
      endcase
      run_op($sformatf("rnd%0d_op%0d", k, op), op, ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit for the execute stage of the MIPS pipeline, placed beside the ALU. It takes the same two register operands the ALU receives and owns the architectural HI/LO registers. Multiply and divide are multi-cycle operations, and `busy` tells the hazard unit to stall any later HI/LO-dependent instruction. MTHI/MTLO write in one cycle. MFHI/MFLO read `hi`/`lo` directly.

## Interface
Parameters:
- MULT_CYCLES, 5, busy duration for MULT/MULTU
- DIV_CYCLES, 10, busy duration for DIV/DIVU

Ports:
- clk, input, 1, rising-edge clock
- reset, input, 1, **asynchronous, active-high**; clears all state
- start, input, 1, one-cycle request to execute `MDUOp`
- MDUOp, input, 3, 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 no-op
- A, input, 32, rs operand (dividend / multiplicand / MT source)
- B, input, 32, rt operand (divisor / multiplier)
- hi, output, 32, architectural HI
- lo, output, 32, architectural LO
- busy, output, 1, multi-cycle operation in flight

## Operation
- Reset values: hi=0, lo=0, busy=0, internal counter=0, shadow result=0.
- States: IDLE (busy=0) and RUN (busy=1). The cycle counter is the only state variable.
- start in IDLE, MULT/MULTU/DIV/DIVU:
  - The operation's result is computed from A/B sampled at that edge and stored in a 64-bit shadow register.
  - The counter loads MULT_CYCLES or DIV_CYCLES, and the unit enters RUN.
- MULT: signed 32×32→64; hi=[63:32], lo=[31:0]. MULTU: unsigned.
- DIV: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend. DIVU: unsigned.
- Divide by zero (B==0): the unit still goes busy for DIV_CYCLES, then leaves hi/lo unchanged.
- MTHI/MTLO in IDLE: hi (or lo) takes A at that edge. busy stays 0.
- start while busy=1 is ignored entirely, including MT ops. The stall logic guarantees it never occurs; the unit must still not corrupt state if it does.
- MDUOp 6–7 with start: no effect.
- In RUN, the counter decrements each edge. At the edge where counter==1:
  - hi/lo take the shadow value, unless the divide-by-zero flag is set.
  - busy falls.
- Reset mid-RUN: busy=0 immediately (asynchronous), hi/lo=0, and the pending result is discarded.

## Timing
- start is sampled at edge E0.
- busy is 1 from after E0 until after E0+N, where N = MULT_CYCLES or DIV_CYCLES. That is exactly N cycles high.
- New hi/lo are visible after edge E0+N, the same edge at which busy falls.
- MTHI/MTLO: new value is visible after E0, zero extra latency.
- hi/lo are register outputs with no combinational path from A/B.
- Back-to-back: start at E0+N (busy just fell) is accepted.
- The external stall condition is `busy | (start & MDUOp∈{0..3})`; the unit does not compute it.

## Configuration
- Macro `MDU_DIV_EN`.
- Defined: DIV/DIVU are implemented as above.
- Undefined:
  - The divider hardware is omitted.
  - DIV/DIVU with start act as no-ops: busy stays 0 and hi/lo are unchanged.
  - DIV_CYCLES is unused.

## Structure
- Shared package `mdu_pkg` holds:
  - MDUOp encodings (MDU_MULT … MDU_MTLO)
  - default MULT_CYCLES/DIV_CYCLES constants
  - operand/result widths
- The ALU op codes are not moved into this package.
- No sub-module: the counter, shadow register and arithmetic are small enough to keep inline in `md_unit`.

## Test plan
- Reset, then start MULT with A=0xFFFFFFFF, B=0x00000002 → busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
- MULTU with the same operands → after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
- DIV with A=0xFFFFFFF9 (−7), B=2 → busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU with A=7, B=2 → lo=3, hi=1.
- MTHI A=0x12345678, then DIVU A=7, B=0 → busy 10 cycles, after which hi stays 0x12345678 and lo stays 0.
- MULT in flight, then at cycle 2 pulse start with MTLO A=0xDEAD → ignored; the final lo is the multiply result.
- MULT in flight, then reset asserted mid-cycle at cycle 3 → busy, hi and lo read 0 before the next edge; no later update occurs.
- With `MDU_DIV_EN` undefined, DIV A=7, B=2 → busy never rises and hi/lo are unchanged.
